round_robin_arbiter_with_hold: RTL and testbench

// - Shares one multi-cycle resource (bus/port) between N requesters, round-robin.
// - Grant is registered and held while the owner keeps its request high.
// - On release the grant moves to the next requester in rotation, without a bubble.
// - Sits between requesters and the shared resource's enable/mux select.
//

---
 rtl/round_robin_arbiter_with_hold_if.sv | 34 +++
 rtl/round_robin_arbiter_with_hold.sv | 162 ++++++++++++++++
 tb/tb_round_robin_arbiter_with_hold.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_robin_arbiter_with_hold_if.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter_with_hold_if
// Purpose  : Request/grant bundle between N requesters and the hold arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface round_robin_arbiter_with_hold_if #(
    parameter int N = 4
) ();
    logic [N-1:0]         requests;
    logic [N-1:0]         grants;
    logic                 grant_valid;
    logic [$clog2(N)-1:0] grant_id;
    logic                 timeout;

    // Requester side drives requests and observes the grant.
    modport master (
        output requests,
        input  grants,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  requests,
        output grants,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/round_robin_arbiter_with_hold.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter_with_hold
// Purpose  : Round-robin arbiter whose registered grant is held while the
//            owner keeps requesting. Optional hold limit: RR_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_with_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    round_robin_arbiter_with_hold_if.slave bus
);

    localparam int c_id_w = $clog2(N);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_grants;
    logic [N-1:0]        w_grants_nxt;
    logic [c_id_w-1:0]   r_grant_id;
    logic [c_id_w-1:0]   w_grant_id_nxt;
    logic [c_id_w-1:0]   r_last_owner;
    logic [c_id_w-1:0]   w_last_owner_nxt;

    logic [N-1:0]        w_arb_req;
    logic                w_win_found;
    logic [c_id_w-1:0]   w_winner;
    logic                w_owner_req;
    logic                w_new_grant;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(MAX_HOLD - 1);

    logic [c_cnt_w-1:0]  r_hold_cnt;
    logic [c_cnt_w-1:0]  w_hold_cnt_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
`endif

    assign w_owner_req = bus.requests[r_last_owner];

    // While busy the owner is always masked: on release its bit is already
    // zero, and on a forced revoke it must not win its own slot again.
    always_comb begin
        w_arb_req   = bus.requests;
        w_win_found = 1'b0;
        w_winner    = '0;
        if (r_state == S_BUSY) begin
            w_arb_req[r_last_owner] = 1'b0;
        end
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = int'(r_last_owner) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_win_found && w_arb_req[c_id_w'(idx)]) begin
                w_win_found = 1'b1;
                w_winner    = c_id_w'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grants_nxt     = r_grants;
        w_grant_id_nxt   = r_grant_id;
        w_last_owner_nxt = r_last_owner;
        w_new_grant      = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        w_hold_cnt_nxt   = r_hold_cnt;
        w_timeout_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_new_grant = w_win_found;
            end
            S_BUSY: begin
                if (!w_owner_req) begin
                    if (w_win_found) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_grants_nxt   = '0;
                        w_grant_id_nxt = '0;
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (r_hold_cnt == c_hold_max) begin
                    if (w_win_found) begin
                        w_new_grant   = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_hold_cnt_nxt = '0;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_new_grant) begin
            w_state_nxt            = S_BUSY;
            w_grants_nxt           = '0;
            w_grants_nxt[w_winner] = 1'b1;
            w_grant_id_nxt         = w_winner;
            w_last_owner_nxt       = w_winner;
`ifdef RR_ARB_TIMEOUT_EN
            w_hold_cnt_nxt         = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grants     <= '0;
            r_grant_id   <= '0;
            r_last_owner <= c_id_w'(N - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grants     <= w_grants_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grants      = r_grants;
    assign bus.grant_valid = |r_grants;
    assign bus.grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter_with_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_robin_arbiter_with_hold
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter_with_hold;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit c_to_en = 1'b1;
`else
    localparam bit c_to_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    round_robin_arbiter_with_hold_if #(.N(N)) bus ();

    round_robin_arbiter_with_hold #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = none), rotation pointer, hold age.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_age   = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int last, input int excl);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_grants();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int model_id();
        return (m_owner >= 0) ? m_owner : 0;
    endfunction

    // Apply inputs at negedge, advance one rising edge, update the model,
    // leave the caller 1 time unit after the edge for sampling.
    task automatic step(input logic [N-1:0] req, input logic r);
        int w;
        @(negedge clk);
        bus.requests = req;
        rst          = r;
        @(posedge clk);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_age   = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_last, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_age = 0;
            end
        end else if (!req[m_owner]) begin
            w = pick(req, m_last, m_owner);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_age = 0;
            end else begin
                m_owner = -1;
            end
        end else if (c_to_en && m_age == MAX_HOLD - 1) begin
            w = pick(req, m_last, m_owner);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_age = 0; m_to = 1'b1;
            end else begin
                m_age = 0;
            end
        end else begin
            m_age = (m_age + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_age + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step('0, 1'b1);
        step('0, 1'b1);
        n_cmp++;
        if (bus.grants !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_grants: got %b want 0000", bus.grants);
        end
        n_cmp++;
        if (bus.grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", bus.grant_valid);
        end
        n_cmp++;
        if (bus.grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_id: got %0d want 0", bus.grant_id);
        end
        n_cmp++;
        if (bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_timeout: got %b want 0", bus.timeout);
        end
    endtask

    task automatic test_hold_and_handoff();
        logic [N-1:0] exp_g [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [N-1:0] req   [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1110};
        step('0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(req[i], 1'b0);
            n_cmp++;
            if (bus.grants !== exp_g[i] || bus.grant_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_handoff[%0d]: got grants=%b valid=%b want grants=%b valid=1",
                         i, bus.grants, bus.grant_valid, exp_g[i]);
            end
        end
    endtask

    task automatic test_owner_release();
        logic [N-1:0] exp_g [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [N-1:0] req   [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        step('0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(req[i], 1'b0);
            n_cmp++;
            if (bus.grants !== exp_g[i] || bus.grant_id !== ((exp_g[i] != 0) ? 2'd2 : 2'd0)) begin
                n_bad++;
                $display("FAIL owner_release[%0d]: got grants=%b id=%0d want grants=%b",
                         i, bus.grants, bus.grant_id, exp_g[i]);
            end
        end
    endtask

    // Continues from the idle state left by test_owner_release (last owner 2).
    task automatic test_rotation_after_idle();
        step(4'b1011, 1'b0);
        n_cmp++;
        if (bus.grants !== 4'b1000 || bus.grant_id !== 2'd3) begin
            n_bad++;
            $display("FAIL rotation_after_idle: got grants=%b id=%0d want grants=1000 id=3",
                     bus.grants, bus.grant_id);
        end
        step(4'b0000, 1'b0);
        n_cmp++;
        if (bus.grants !== 4'b0000 || bus.grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rotation_release: got grants=%b valid=%b want 0000/0",
                     bus.grants, bus.grant_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        step('0, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0010, 1'b0);
        n_cmp++;
        if (bus.grants !== 4'b0010) begin
            n_bad++;
            $display("FAIL mid_grant_setup: got grants=%b want 0010", bus.grants);
        end
        step(4'b0010, 1'b1);
        n_cmp++;
        if (bus.grants !== 4'b0000 || bus.grant_id !== 2'd0 || bus.grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_grant_reset: got grants=%b id=%0d valid=%b want 0000/0/0",
                     bus.grants, bus.grant_id, bus.grant_valid);
        end
        step(4'b0011, 1'b0);
        n_cmp++;
        if (bus.grants !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_grant_after: got grants=%b want 0001", bus.grants);
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_g [9];
        logic         exp_t [9];
        for (int i = 0; i < 9; i++) begin
            exp_g[i] = 4'b0001;
            exp_t[i] = 1'b0;
        end
        if (c_to_en) begin
            for (int i = 4; i < 8; i++) exp_g[i] = 4'b0010;
            exp_t[4] = 1'b1;
            exp_t[8] = 1'b1;
        end
        step('0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(4'b0011, 1'b0);
            n_cmp++;
            if (bus.grants !== exp_g[i] || bus.timeout !== exp_t[i]) begin
                n_bad++;
                $display("FAIL timeout_pair[%0d]: got grants=%b timeout=%b want grants=%b timeout=%b",
                         i, bus.grants, bus.timeout, exp_g[i], exp_t[i]);
            end
        end
        step('0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(4'b0100, 1'b0);
            n_cmp++;
            if (bus.grants !== 4'b0100 || bus.timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_sole[%0d]: got grants=%b timeout=%b want grants=0100 timeout=0",
                         i, bus.grants, bus.timeout);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic         r;
        req = '0;
        step('0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) req[m_owner] = 1'b0;
            r = ($urandom_range(0, 99) == 0);
            step(req, r);
            n_cmp++;
            if (bus.grants !== model_grants() || bus.grant_valid !== (m_owner >= 0) ||
                bus.grant_id !== 2'(model_id()) || bus.timeout !== m_to) begin
                n_bad++;
                $display("FAIL random[%0d] req=%b: got grants=%b valid=%b id=%0d timeout=%b want grants=%b valid=%b id=%0d timeout=%b",
                         i, req, bus.grants, bus.grant_valid, bus.grant_id, bus.timeout,
                         model_grants(), (m_owner >= 0), model_id(), m_to);
            end
        end
    endtask

    initial begin
        bus.requests = '0;
        test_reset();
        test_hold_and_handoff();
        test_owner_release();
        test_rotation_after_idle();
        test_reset_mid_grant();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
